// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage delay pipe with valid, stall, flush, occ.
// Ports: clk, n_rst (async low), en, flush, d, d_vld -> q, q_vld, occ.
// Optional DFF_PIPE_PARITY_EN adds err_inj input and par_err output.
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
`ifdef DFF_PIPE_PARITY_EN
  input  logic             err_inj,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic [OCC_W-1:0] occ
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0]            vld_d;
  logic [OCC_W-1:0]            occ_q;
  logic [OCC_W-1:0]            occ_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    occ_d  = occ_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RST_VAL;
      end
      vld_d = '0;
      occ_d = '0;
    end else if (en) begin
      data_d[0] = d;
      vld_d[0]  = d_vld;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      // In and out together leave the count unchanged.
      occ_d = occ_q
            + OCC_W'(d_vld)
            - OCC_W'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RST_VAL;
      end
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      occ_q  <= occ_d;
    end
  end

  assign q     = data_q[DEPTH-1];
  assign q_vld = vld_q[DEPTH-1];
  assign occ   = occ_q;

`ifdef DFF_PIPE_PARITY_EN
  localparam logic RST_PAR = ^RST_VAL;

  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] par_d;

  always_comb begin
    par_d = par_q;
    if (flush) begin
      par_d = {DEPTH{RST_PAR}};
    end else if (en) begin
      par_d[0] = (^d) ^ err_inj;
      for (int i = 1; i < DEPTH; i++) begin
        par_d[i] = par_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_q <= {DEPTH{RST_PAR}};
    end else begin
      par_q <= par_d;
    end
  end

  // Only a valid word can report a parity error.
  assign par_err = vld_q[DEPTH-1]
                 & ((^data_q[DEPTH-1])
                 ^ par_q[DEPTH-1]);
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: scoreboard bench for dff_pipe (WIDTH=8, DEPTH=4).
// Directed vectors; monitor pops expected words as they leave q.
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             n_rst;
  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_vld;
  logic [WIDTH-1:0] q;
  logic             q_vld;
  logic [OW-1:0]    occ;
`ifdef DFF_PIPE_PARITY_EN
  logic             err_inj;
  logic             par_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [DEPTH-1:0] ref_vld;

  always #5 clk = ~clk;

  dff_pipe #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .RST_VAL(8'h00)
  ) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .en     (en),
    .flush  (flush),
    .d      (d),
    .d_vld  (d_vld),
`ifdef DFF_PIPE_PARITY_EN
    .err_inj(err_inj),
    .par_err(par_err),
`endif
    .q      (q),
    .q_vld  (q_vld),
    .occ    (occ)
  );

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, record expected words, step an edge.
  task automatic drive(logic e, logic f,
                       logic [WIDTH-1:0] dd, logic v);
    en    = e;
    flush = f;
    d     = dd;
    d_vld = v;
    if (f) exp_q.delete();
    else if (e && v && n_rst) exp_q.push_back(dd);
    @(posedge clk);
    #1;
  endtask

  // Valid-bit reference for latency and occupancy.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) ref_vld <= '0;
    else if (flush) ref_vld <= '0;
    else if (en) ref_vld <= {ref_vld[DEPTH-2:0], d_vld};
  end

  // Monitor: per-cycle invariants, pop a word as it leaves.
  always @(negedge clk) begin
    if (n_rst) begin
      check("q_vld_ref", 32'(q_vld),
            32'(ref_vld[DEPTH-1]));
      check("occ_popcount", 32'(occ),
            32'($countones(ref_vld)));
`ifdef DFF_PIPE_PARITY_EN
      if (!q_vld) check("par_err_idle", 32'(par_err), 0);
`endif
      if (q_vld && en && !flush) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: got q=%0h expected none",
                   q);
        end else begin
          check("sb_data", 32'(q), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int occ_t2 [6];
    occ_t2 = '{1, 2, 3, 4, 4, 4};
    n_rst = 1'b0;
    en    = 1'b1;
    flush = 1'b0;
    d     = 8'hFF;
    d_vld = 1'b1;
`ifdef DFF_PIPE_PARITY_EN
    err_inj = 1'b0;
`endif
    #1;
    check("rst_q", 32'(q), 32'h00);
    check("rst_q_vld", 32'(q_vld), 0);
    check("rst_occ", 32'(occ), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_q", 32'(q), 32'h00);
      check("rst_hold_q_vld", 32'(q_vld), 0);
      check("rst_hold_occ", 32'(occ), 0);
    end

    // T1: single word, latency 4.
    n_rst = 1'b1;
    drive(1, 0, 8'hA5, 1);
    drive(1, 0, 8'h00, 0);
    check("t1_e2_vld", 32'(q_vld), 0);
    drive(1, 0, 8'h00, 0);
    check("t1_e3_vld", 32'(q_vld), 0);
    drive(1, 0, 8'h00, 0);
    check("t1_e4_q", 32'(q), 32'hA5);
    check("t1_e4_vld", 32'(q_vld), 1);
    drive(1, 0, 8'h00, 0);
    check("t1_e5_vld", 32'(q_vld), 0);

    // T2: stream 1..6.
    for (int i = 1; i <= 6; i++) begin
      drive(1, 0, 8'(i), 1);
      check("t2_occ", 32'(occ), 32'(occ_t2[i-1]));
      if (i >= 4) check("t2_q", 32'(q), 32'(i - 3));
    end
    for (int i = 0; i < 4; i++) drive(1, 0, 8'h00, 0);
    check("t2_drained_occ", 32'(occ), 0);

    // T3: stall holds everything.
    drive(1, 0, 8'h11, 1);
    drive(1, 0, 8'h22, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'(8'h40 + i), 1);
      check("t3_stall_q", 32'(q), 32'h00);
      check("t3_stall_vld", 32'(q_vld), 0);
      check("t3_stall_occ", 32'(occ), 2);
    end
    drive(1, 0, 8'h00, 0);
    check("t3_r1_vld", 32'(q_vld), 0);
    drive(1, 0, 8'h00, 0);
    check("t3_r2_q", 32'(q), 32'h11);
    check("t3_r2_vld", 32'(q_vld), 1);
    drive(1, 0, 8'h00, 0);
    check("t3_r3_q", 32'(q), 32'h22);
    check("t3_r3_vld", 32'(q_vld), 1);
    drive(1, 0, 8'h00, 0);
    check("t3_r4_vld", 32'(q_vld), 0);
    check("t3_r4_occ", 32'(occ), 0);

    // T4: flush beats en; flushed-cycle word is lost.
    for (int i = 0; i < 4; i++) drive(1, 0, 8'(8'h31 + i), 1);
    check("t4_full_occ", 32'(occ), 4);
    check("t4_full_q", 32'(q), 32'h31);
    drive(1, 1, 8'h99, 1);
    check("t4_fl_q", 32'(q), 32'h00);
    check("t4_fl_vld", 32'(q_vld), 0);
    check("t4_fl_occ", 32'(occ), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'h00, 0);
      check("t4_post_vld", 32'(q_vld), 0);
    end

    // T5: alternating valid, window popcount settles at 2.
    begin
      int occ_t5 [8];
      occ_t5 = '{1, 1, 2, 2, 2, 2, 2, 2};
      for (int i = 0; i < 8; i++) begin
        drive(1, 0, 8'(8'h50 + i), 1'((i + 1) % 2));
        check("t5_occ", 32'(occ), 32'(occ_t5[i]));
        if (i >= 3)
          check("t5_q_vld", 32'(q_vld), 32'((i - 2) % 2));
      end
    end
    for (int i = 0; i < 4; i++) drive(1, 0, 8'h00, 0);

`ifdef DFF_PIPE_PARITY_EN
    // T6: injected parity error follows its word.
    err_inj = 1'b1;
    drive(1, 0, 8'h03, 1);
    err_inj = 1'b0;
    drive(1, 0, 8'h07, 1);
    drive(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);
    check("t6_q03", 32'(q), 32'h03);
    check("t6_perr1", 32'(par_err), 1);
    drive(1, 0, 8'h00, 0);
    check("t6_q07", 32'(q), 32'h07);
    check("t6_perr0", 32'(par_err), 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 8'h00, 0);
`endif

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
